// File: rtl/strb_to_axis_if.sv
// Strobe-in / AXI-stream-out bundle for strb_to_axis.
// master: the adapter's view; slave: the producer/consumer side.
interface strb_to_axis_if #(
    parameter int WIDTH = 2
);
    logic             i_strb;
    logic [WIDTH-1:0] i_data;
    logic             o_tvalid;
    logic             o_tready;
    logic [WIDTH-1:0] o_tdata;

    modport master (
        input  i_strb,
        input  i_data,
        input  o_tready,
        output o_tvalid,
        output o_tdata
    );

    modport slave (
        output i_strb,
        output i_data,
        output o_tready,
        input  o_tvalid,
        input  o_tdata
    );
endinterface

// File: rtl/strb_to_axis.sv
// Strobe+data (no backpressure) to AXI-stream adapter with a small FIFO and drop detection.
// Define STRB_AXIS_OVF_CNT_EN to add the saturating dropped-word counter o_ovf_cnt.
module strb_to_axis #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
`ifdef STRB_AXIS_OVF_CNT_EN
    ,
    parameter int OVF_CNT_WIDTH = 8
`endif
) (
    input  logic                    clk,
    input  logic                    aresetn,
    strb_to_axis_if.master          bus,
    output logic [$clog2(DEPTH):0]  o_level,
    input  logic                    ovf_clr,
    output logic                    o_ovf
`ifdef STRB_AXIS_OVF_CNT_EN
    ,
    output logic [OVF_CNT_WIDTH-1:0] o_ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic [AW:0]      level_next;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [WIDTH-1:0] tdata_next;

    always_comb begin
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = bus.o_tvalid && bus.o_tready;
        push       = bus.i_strb && (!full || pop);
        drop       = bus.i_strb && !push;
        rd_next    = rd_ptr + (AW+1)'(pop);
        wr_next    = wr_ptr + (AW+1)'(push);
        level_next = wr_next - rd_next;
        tdata_next = bus.o_tdata;
        // A word written into a FIFO that is empty after this edge's pop becomes
        // the new head, so it is taken from i_data rather than the not-yet-written slot.
        if (level_next != '0) begin
            if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0]))
                tdata_next = bus.i_data;
            else
                tdata_next = mem[rd_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= bus.i_data;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_level      <= '0;
            bus.o_tvalid <= 1'b0;
            bus.o_tdata  <= '0;
            o_ovf        <= 1'b0;
        end else begin
            wr_ptr       <= wr_next;
            rd_ptr       <= rd_next;
            o_level      <= level_next;
            bus.o_tvalid <= (level_next != '0);
            bus.o_tdata  <= tdata_next;
            if (drop)
                o_ovf <= 1'b1;
            else if (ovf_clr)
                o_ovf <= 1'b0;
        end
    end

`ifdef STRB_AXIS_OVF_CNT_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            o_ovf_cnt <= '0;
        else if (drop && (o_ovf_cnt != '1))
            o_ovf_cnt <= o_ovf_cnt + OVF_CNT_WIDTH'(1);
    end
`endif

endmodule

// File: tb/tb_strb_to_axis.sv
// Scoreboard bench for strb_to_axis (WIDTH=8, DEPTH=4); covers STRB_AXIS_OVF_CNT_EN when defined.
module tb_strb_to_axis;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       aresetn = 1'b0;
    logic [2:0] o_level;
    logic       ovf_clr = 1'b0;
    logic       o_ovf;
`ifdef STRB_AXIS_OVF_CNT_EN
    logic [7:0] o_ovf_cnt;
`endif

    strb_to_axis_if #(.WIDTH(WIDTH)) bus ();

    strb_to_axis #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
`ifdef STRB_AXIS_OVF_CNT_EN
        ,
        .OVF_CNT_WIDTH(8)
`endif
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .bus(bus),
        .o_level(o_level),
        .ovf_clr(ovf_clr),
        .o_ovf(o_ovf)
`ifdef STRB_AXIS_OVF_CNT_EN
        ,
        .o_ovf_cnt(o_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model: queue of words the consumer must see, plus occupancy and flags.
    logic [WIDTH-1:0] exp_q [$];
    int               cnt_m = 0;
    logic             ovf_m = 1'b0;
    int               ovfcnt_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check state from the previous edge, then drive and predict this edge.
    task automatic step(input logic s, input logic [WIDTH-1:0] d, input logic r, input logic c);
        bit pop_m;
        bit push_m;
        bit drop_m;
        @(negedge clk);
        chk("tvalid", {31'd0, bus.o_tvalid}, {31'd0, cnt_m > 0});
        chk("level", {29'd0, o_level}, cnt_m);
        chk("ovf", {31'd0, o_ovf}, {31'd0, ovf_m});
`ifdef STRB_AXIS_OVF_CNT_EN
        chk("ovf_cnt", {24'd0, o_ovf_cnt}, ovfcnt_m);
`endif
        bus.i_strb   = s;
        bus.i_data   = d;
        bus.o_tready = r;
        ovf_clr      = c;
        pop_m  = (cnt_m > 0) && r;
        push_m = s && ((cnt_m < DEPTH) || pop_m);
        drop_m = s && !push_m;
        if (push_m) exp_q.push_back(d);
        cnt_m = cnt_m + int'(push_m) - int'(pop_m);
        if (drop_m) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
        if (drop_m && ovfcnt_m < 255) ovfcnt_m++;
    endtask

    task automatic fill4();
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks AXI hold rules.
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        #2;
        if (!aresetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_tvalid", {31'd0, bus.o_tvalid}, 32'd1);
                chk("hold_tdata", {24'd0, bus.o_tdata}, {24'd0, prev_data});
            end
            if (bus.o_tvalid && bus.o_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, bus.o_tdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", {24'd0, bus.o_tdata}, {24'd0, e});
                end
            end
            prev_hold = bus.o_tvalid && !bus.o_tready;
            prev_data = bus.o_tdata;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.i_strb   = 1'b0;
        bus.i_data   = '0;
        bus.o_tready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        chk("rst_level", {29'd0, o_level}, 32'd0);
        chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
        chk("rst_tdata", {24'd0, bus.o_tdata}, 32'd0);
        @(negedge clk);
        aresetn = 1'b1;

        // Single word: push at edge 1, visible after it, popped at edge 2.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("single_tdata", {24'd0, bus.o_tdata}, 32'hA5);
        step(1'b0, '0, 1'b1, 1'b0);

        // Backpressure and fill
        fill4();
        step(1'b0, '0, 1'b0, 1'b0);
        chk("fill_head", {24'd0, bus.o_tdata}, 32'h01);
        drain(5);

        // Overflow drop
        fill4();
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_level_full", {29'd0, o_level}, 32'd4);
        drain(5);

        // Full with simultaneous push and pop: no drop
        step(1'b0, '0, 1'b0, 1'b1);
        fill4();
        step(1'b1, 8'h05, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("pushpop_ovf", {31'd0, o_ovf}, 32'd0);
        drain(6);

        // Set wins over clear, then clear alone
        fill4();
        step(1'b1, 8'h66, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        drain(6);

`ifdef STRB_AXIS_OVF_CNT_EN
        fill4();
        for (int i = 0; i < 300; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("ovf_cnt_sat", {24'd0, o_ovf_cnt}, 32'd255);
        drain(6);
`endif

        // Reset mid-stream with 3 words held and o_ovf set
        fill4();
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        #1;
        aresetn = 1'b0;
        #1;
        chk("async_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        chk("async_level", {29'd0, o_level}, 32'd0);
        chk("async_ovf", {31'd0, o_ovf}, 32'd0);
        exp_q.delete();
        cnt_m = 0;
        ovf_m = 1'b0;
        ovfcnt_m = 0;
        @(posedge clk);
        #2;
        aresetn = 1'b1;
        step(1'b1, 8'h77, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("after_rst_first", {24'd0, bus.o_tdata}, 32'h77);
        drain(2);

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));

        k = 0;
        while (cnt_m > 0 && k < 50) begin
            step(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        step(1'b0, '0, 1'b1, 1'b0);
        #3;
        chk("drain_done", cnt_m, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
